// File: rtl/riscv_core_pkg.sv
// Shared types for the integer issue queue: ALU op codes, the queue entry
// record, default sizing, and the CDB tag-match / capture helpers used for
// both resident and newly dispatched entries.
package riscv_core_pkg;

    localparam int IQ_LENGTH = 32;
    localparam int IQ_TAG_W  = 5;
    localparam int IQ_DEPTH  = 4;
    localparam int IQ_CNT_W  = $clog2(IQ_DEPTH + 1);

    typedef enum logic [3:0] {
        ADD  = 4'h0,
        SUB  = 4'h1,
        MUL  = 4'h2,
        SLL  = 4'h3,
        SLT  = 4'h4,
        XOR  = 4'h5,
        SRL  = 4'h6,
        OR   = 4'h7,
        AND  = 4'h8,
        SLLI = 4'h9,
        SRLI = 4'hA
    } alu_op_e;

    // op is kept as raw bits so that codes above SRLI travel through untouched
    typedef struct packed {
        logic                 valid;
        logic [3:0]           op;
        logic [IQ_TAG_W-1:0]  dst_tag;
        logic                 rdy1;
        logic                 rdy2;
        logic [IQ_TAG_W-1:0]  tag1;
        logic [IQ_TAG_W-1:0]  tag2;
        logic [IQ_LENGTH-1:0] val1;
        logic [IQ_LENGTH-1:0] val2;
    } iq_entry_t;

    // An operand wakes up when it is still waiting and its producer is on the CDB
    function automatic logic iq_wake(input logic                valid,
                                     input logic                rdy,
                                     input logic [IQ_TAG_W-1:0] tag,
                                     input logic                cdb_valid,
                                     input logic [IQ_TAG_W-1:0] cdb_tag);
        return valid && !rdy && cdb_valid && (tag == cdb_tag);
    endfunction

    // Entry as it looks after this cycle's CDB broadcast has been captured
    function automatic iq_entry_t iq_capture(input iq_entry_t            e,
                                             input logic                 cdb_valid,
                                             input logic [IQ_TAG_W-1:0]  cdb_tag,
                                             input logic [IQ_LENGTH-1:0] cdb_data);
        iq_entry_t r;
        r = e;
        if (iq_wake(e.valid, e.rdy1, e.tag1, cdb_valid, cdb_tag)) begin
            r.rdy1 = 1'b1;
            r.val1 = cdb_data;
        end
        if (iq_wake(e.valid, e.rdy2, e.tag2, cdb_valid, cdb_tag)) begin
            r.rdy2 = 1'b1;
            r.val2 = cdb_data;
        end
        return r;
    endfunction

endpackage

// File: rtl/iq_oldest_picker.sv
// Fixed-priority picker: the lowest-index (oldest) requesting entry wins.
// Returns a one-hot grant, the binary index of the winner and a found flag.
module iq_oldest_picker #(
    parameter int DEPTH = 4,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] req,
    output logic [DEPTH-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scan from oldest to youngest and latch onto the first request seen
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (req[i] && !found) begin
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_issue_queue.sv
// Integer reservation station in front of the 32-bit ALU. Entries are kept
// age-ordered and compacted (entry 0 oldest); operands are captured from the
// CDB and the oldest fully-ready op is presented on the issue port.
// Optional build macro IQ_CDB_BYPASS_EN: lets an entry whose last missing
// operand(s) are on the CDB this cycle issue immediately with the CDB data.
module int_issue_queue
    import riscv_core_pkg::*;
#(
    parameter int LENGTH = IQ_LENGTH,
    parameter int DEPTH  = IQ_DEPTH,
    parameter int TAG_W  = IQ_TAG_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       disp_valid_i,
    output logic                       disp_ready_o,
    input  logic [3:0]                 disp_op_i,
    input  logic [TAG_W-1:0]           disp_dst_tag_i,
    input  logic                       disp_src1_rdy_i,
    input  logic [TAG_W-1:0]           disp_src1_tag_i,
    input  logic [LENGTH-1:0]          disp_src1_val_i,
    input  logic                       disp_src2_rdy_i,
    input  logic [TAG_W-1:0]           disp_src2_tag_i,
    input  logic [LENGTH-1:0]          disp_src2_val_i,
    input  logic                       cdb_valid_i,
    input  logic [TAG_W-1:0]           cdb_tag_i,
    input  logic [LENGTH-1:0]          cdb_data_i,
    output logic                       issue_valid_o,
    input  logic                       issue_ready_i,
    output logic [3:0]                 issue_op_o,
    output logic [LENGTH-1:0]          issue_a_o,
    output logic [LENGTH-1:0]          issue_b_o,
    output logic [TAG_W-1:0]           issue_dst_tag_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    iq_entry_t        entry_reg   [DEPTH];
    iq_entry_t        entry_woken [DEPTH];
    iq_entry_t        entry_above [DEPTH];
    iq_entry_t        entry_kept  [DEPTH];
    iq_entry_t        entry_next  [DEPTH];
    iq_entry_t        disp_entry;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] disp_pos;
    logic [DEPTH-1:0] sel_req;
    logic [DEPTH-1:0] sel_grant;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic             issue_fire;
    logic             disp_fire;

    // Handshakes; ready depends only on the registered count
    assign disp_ready_o = (count_reg != CNT_W'(DEPTH));
    assign disp_fire    = disp_valid_i & disp_ready_o;
    assign issue_fire   = sel_found & issue_ready_i;
    assign count_o      = count_reg;

    // A same-cycle issue frees the slot just below the tail
    assign disp_pos   = count_reg - CNT_W'(issue_fire);
    assign count_next = count_reg + CNT_W'(disp_fire) - CNT_W'(issue_fire);

    // Incoming op with any matching CDB operand captured on the way in
    assign disp_entry = iq_capture('{valid:   1'b1,
                                     op:      disp_op_i,
                                     dst_tag: disp_dst_tag_i,
                                     rdy1:    disp_src1_rdy_i,
                                     rdy2:    disp_src2_rdy_i,
                                     tag1:    disp_src1_tag_i,
                                     tag2:    disp_src2_tag_i,
                                     val1:    disp_src1_val_i,
                                     val2:    disp_src2_val_i},
                                   cdb_valid_i, cdb_tag_i, cdb_data_i);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign entry_woken[gi] = iq_capture(entry_reg[gi], cdb_valid_i, cdb_tag_i, cdb_data_i);

`ifdef IQ_CDB_BYPASS_EN
            assign sel_req[gi] = entry_woken[gi].valid & entry_woken[gi].rdy1 & entry_woken[gi].rdy2;
`else
            assign sel_req[gi] = entry_reg[gi].valid & entry_reg[gi].rdy1 & entry_reg[gi].rdy2;
`endif

            // Compaction source: the youngest slot refills with an empty entry
            if (gi < DEPTH - 1) begin : g_mid
                assign entry_above[gi] = entry_woken[gi+1];
            end else begin : g_top
                assign entry_above[gi] = '0;
            end

            assign entry_kept[gi] = (issue_fire && (IDX_W'(gi) >= sel_idx)) ? entry_above[gi]
                                                                              : entry_woken[gi];
            assign entry_next[gi] = (disp_fire && (disp_pos == CNT_W'(gi))) ? disp_entry
                                                                             : entry_kept[gi];
        end
    endgenerate

    iq_oldest_picker #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (sel_req),
        .grant (sel_grant),
        .idx   (sel_idx),
        .found (sel_found)
    );

    // Issue mux; the woken view equals the registered one unless bypass let a CDB value in
    always_comb begin
        issue_valid_o   = sel_found;
        issue_op_o      = '0;
        issue_a_o       = '0;
        issue_b_o       = '0;
        issue_dst_tag_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_grant[i]) begin
                issue_op_o      = entry_woken[i].op;
                issue_a_o       = entry_woken[i].val1;
                issue_b_o       = entry_woken[i].val2;
                issue_dst_tag_o = entry_woken[i].dst_tag;
            end
        end
    end

    // Queue state: reset, then flush, then normal dispatch/issue/wakeup update
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_reg[i] <= '0;
            end
            count_reg <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_reg[i].valid <= 1'b0;
            end
            count_reg <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_reg[i] <= entry_next[i];
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: tb/tb_int_issue_queue.sv
// Testbench for int_issue_queue: directed scenarios plus random traffic
// against an age-ordered list model; a monitor compares every cycle.
module tb_int_issue_queue;
    import riscv_core_pkg::*;

    localparam int LENGTH = 32;
    localparam int DEPTH  = 4;
    localparam int TAG_W  = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush_i;
    logic              disp_valid_i;
    logic              disp_ready_o;
    logic [3:0]        disp_op_i;
    logic [TAG_W-1:0]  disp_dst_tag_i;
    logic              disp_src1_rdy_i;
    logic [TAG_W-1:0]  disp_src1_tag_i;
    logic [LENGTH-1:0] disp_src1_val_i;
    logic              disp_src2_rdy_i;
    logic [TAG_W-1:0]  disp_src2_tag_i;
    logic [LENGTH-1:0] disp_src2_val_i;
    logic              cdb_valid_i;
    logic [TAG_W-1:0]  cdb_tag_i;
    logic [LENGTH-1:0] cdb_data_i;
    logic              issue_valid_o;
    logic              issue_ready_i;
    logic [3:0]        issue_op_o;
    logic [LENGTH-1:0] issue_a_o;
    logic [LENGTH-1:0] issue_b_o;
    logic [TAG_W-1:0]  issue_dst_tag_o;
    logic [2:0]        count_o;

    always #5 clk = ~clk;

    int_issue_queue #(.LENGTH(LENGTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush_i         (flush_i),
        .disp_valid_i    (disp_valid_i),
        .disp_ready_o    (disp_ready_o),
        .disp_op_i       (disp_op_i),
        .disp_dst_tag_i  (disp_dst_tag_i),
        .disp_src1_rdy_i (disp_src1_rdy_i),
        .disp_src1_tag_i (disp_src1_tag_i),
        .disp_src1_val_i (disp_src1_val_i),
        .disp_src2_rdy_i (disp_src2_rdy_i),
        .disp_src2_tag_i (disp_src2_tag_i),
        .disp_src2_val_i (disp_src2_val_i),
        .cdb_valid_i     (cdb_valid_i),
        .cdb_tag_i       (cdb_tag_i),
        .cdb_data_i      (cdb_data_i),
        .issue_valid_o   (issue_valid_o),
        .issue_ready_i   (issue_ready_i),
        .issue_op_o      (issue_op_o),
        .issue_a_o       (issue_a_o),
        .issue_b_o       (issue_b_o),
        .issue_dst_tag_o (issue_dst_tag_o),
        .count_o         (count_o)
    );

    typedef struct {
        logic [3:0]       op;
        logic [TAG_W-1:0] dst;
        bit               r1;
        bit               r2;
        logic [TAG_W-1:0] t1;
        logic [TAG_W-1:0] t2;
        logic [31:0]      v1;
        logic [31:0]      v2;
    } mop_t;

    typedef struct {
        int               count;
        bit               dready;
        bit               ivalid;
        bit               fire;
        logic [3:0]       op;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] dst;
    } exp_t;

    mop_t model_q[$];
    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_issued = 0;

    // Apply the inputs for one cycle, predict the outputs, advance the model
    task automatic step(input bit rn, input bit fl, input bit dv, input logic [3:0] op,
                        input logic [TAG_W-1:0] dst,
                        input bit r1, input logic [TAG_W-1:0] t1, input logic [31:0] v1,
                        input bit r2, input logic [TAG_W-1:0] t2, input logic [31:0] v2,
                        input bit cv, input logic [TAG_W-1:0] ct, input logic [31:0] cd,
                        input bit ir);
        exp_t e;
        mop_t m;
        int   sel;
        int   n_before;
        rst_n = rn; flush_i = fl; disp_valid_i = dv; disp_op_i = op; disp_dst_tag_i = dst;
        disp_src1_rdy_i = r1; disp_src1_tag_i = t1; disp_src1_val_i = v1;
        disp_src2_rdy_i = r2; disp_src2_tag_i = t2; disp_src2_val_i = v2;
        cdb_valid_i = cv; cdb_tag_i = ct; cdb_data_i = cd; issue_ready_i = ir;

        n_before = model_q.size();
        e.count = n_before; e.dready = (n_before < DEPTH);
        e.ivalid = 0; e.op = '0; e.a = '0; e.b = '0; e.dst = '0;
        sel = -1;
        for (int i = 0; i < n_before; i++) begin
            bit          a_ok;
            bit          b_ok;
            logic [31:0] av;
            logic [31:0] bv;
            a_ok = model_q[i].r1; av = model_q[i].v1;
            b_ok = model_q[i].r2; bv = model_q[i].v2;
`ifdef IQ_CDB_BYPASS_EN
            if (!a_ok && cv && model_q[i].t1 == ct) begin a_ok = 1; av = cd; end
            if (!b_ok && cv && model_q[i].t2 == ct) begin b_ok = 1; bv = cd; end
`endif
            if (a_ok && b_ok && sel < 0) begin
                sel = i; e.ivalid = 1; e.op = model_q[i].op;
                e.a = av; e.b = bv; e.dst = model_q[i].dst;
            end
        end
        e.fire = e.ivalid && ir;
        exp_q.push_back(e);

        if (!rn || fl) begin
            model_q.delete();
        end else begin
            for (int i = 0; i < n_before; i++) begin
                if (cv && !model_q[i].r1 && model_q[i].t1 == ct) begin model_q[i].r1 = 1; model_q[i].v1 = cd; end
                if (cv && !model_q[i].r2 && model_q[i].t2 == ct) begin model_q[i].r2 = 1; model_q[i].v2 = cd; end
            end
            if (e.fire) model_q.delete(sel);
            if (dv && n_before < DEPTH) begin
                m.op = op; m.dst = dst; m.r1 = r1; m.r2 = r2; m.t1 = t1; m.t2 = t2; m.v1 = v1; m.v2 = v2;
                if (cv && !m.r1 && m.t1 == ct) begin m.r1 = 1; m.v1 = cd; end
                if (cv && !m.r2 && m.t2 == ct) begin m.r2 = 1; m.v2 = cd; end
                model_q.push_back(m);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit ir);
        step(1, 0, 0, 4'h0, '0, 1, '0, '0, 1, '0, '0, 0, '0, '0, ir);
    endtask

    task automatic disp(input logic [3:0] op, input logic [TAG_W-1:0] dst,
                        input bit r1, input logic [TAG_W-1:0] t1, input logic [31:0] v1,
                        input bit r2, input logic [TAG_W-1:0] t2, input logic [31:0] v2,
                        input bit ir);
        step(1, 0, 1, op, dst, r1, t1, v1, r2, t2, v2, 0, '0, '0, ir);
    endtask

    task automatic cdb(input logic [TAG_W-1:0] ct, input logic [31:0] cd, input bit ir);
        step(1, 0, 0, 4'h0, '0, 1, '0, '0, 1, '0, '0, 1, ct, cd, ir);
    endtask

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, expv, $time);
        end
    endfunction

    // Monitor: one expected record per cycle, compared away from the clock edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("count_o", 32'(count_o), 32'(e.count));
                chk("disp_ready_o", 32'(disp_ready_o), 32'(e.dready));
                chk("issue_valid_o", 32'(issue_valid_o), 32'(e.ivalid));
                chk("issue_op_o", 32'(issue_op_o), 32'(e.op));
                chk("issue_a_o", issue_a_o, e.a);
                chk("issue_b_o", issue_b_o, e.b);
                chk("issue_dst_tag_o", 32'(issue_dst_tag_o), 32'(e.dst));
                if (e.fire) begin
                    n_issued++;
                    $display("issue #%0d op=%0h a=%08h b=%08h dst=%0d", n_issued,
                             issue_op_o, issue_a_o, issue_b_o, issue_dst_tag_o);
                end
            end
        end
    end

    initial begin
        logic [TAG_W-1:0] ct;
        int               k;
        rst_n = 0; flush_i = 0; disp_valid_i = 0; disp_op_i = '0; disp_dst_tag_i = '0;
        disp_src1_rdy_i = 0; disp_src1_tag_i = '0; disp_src1_val_i = '0;
        disp_src2_rdy_i = 0; disp_src2_tag_i = '0; disp_src2_val_i = '0;
        cdb_valid_i = 0; cdb_tag_i = '0; cdb_data_i = '0; issue_ready_i = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, then ADD 5,7 -> dst 3 issues the cycle after dispatch
        idle(0);
        disp(ADD, 5'd3, 1, '0, 32'd5, 1, '0, 32'd7, 0);
        idle(1);
        idle(0);

        // Older SUB waits on tag 9, younger XOR overtakes; CDB then releases SUB
        disp(SUB, 5'd1, 0, 5'd9, '0, 1, '0, 32'd3, 0);
        disp(XOR, 5'd2, 1, '0, 32'd10, 1, '0, 32'd12, 0);
        idle(1);
        cdb(5'd9, 32'h20, 1);
        idle(1);
        idle(0);

        // Fill with non-ready ops, attempt a fifth, wake entry 2 and hold it
        disp(MUL, 5'd4, 0, 5'd10, '0, 1, '0, 32'd1, 1);
        disp(SLL, 5'd5, 0, 5'd11, '0, 1, '0, 32'd2, 1);
        disp(SLT, 5'd6, 0, 5'd12, '0, 1, '0, 32'd3, 1);
        disp(OR,  5'd7, 0, 5'd13, '0, 1, '0, 32'd4, 1);
        disp(AND, 5'd8, 1, '0, 32'd9, 1, '0, 32'd9, 1);
        cdb(5'd12, 32'h33, 0);
        idle(0);
        idle(1);
        cdb(5'd13, 32'h44, 1);
        cdb(5'd10, 32'h55, 1);
        cdb(5'd11, 32'h66, 1);
        idle(1);
        idle(1);

        // Dispatch capturing src2 from the CDB in the same cycle
        step(1, 0, 1, SRL, 5'd9, 1, '0, 32'd1, 0, 5'd6, '0, 1, 5'd6, 32'hFFFF_FFFF, 0);
        idle(1);

        // Flush with a simultaneous dispatch, then reset mid-stream
        disp(SLLI, 5'd1, 0, 5'd20, '0, 1, '0, '0, 0);
        disp(SRLI, 5'd2, 0, 5'd21, '0, 1, '0, '0, 0);
        disp(4'hF, 5'd3, 1, '0, 32'd1, 1, '0, 32'd2, 0);
        step(1, 1, 1, ADD, 5'd4, 1, '0, 32'd1, 1, '0, 32'd1, 0, '0, '0, 1);
        idle(1);
        disp(4'hE, 5'd1, 1, '0, 32'hA, 1, '0, 32'hB, 0);
        disp(SUB, 5'd2, 0, 5'd4, '0, 1, '0, 32'd5, 0);
        step(0, 0, 1, ADD, 5'd4, 1, '0, 32'd1, 1, '0, 32'd1, 0, '0, '0, 1);
        idle(1);

        // Waiting on tag 4: bypass issues in the CDB cycle, otherwise one later
        disp(XOR, 5'd5, 0, 5'd4, '0, 1, '0, 32'd6, 0);
        cdb(5'd4, 32'h11, 1);
        idle(1);
        disp(4'hF, 5'd6, 1, '0, 32'h1234, 1, '0, 32'h5678, 0);
        idle(1);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            ct = 5'($urandom_range(0, 7));
            if (model_q.size() > 0 && $urandom_range(0, 9) < 7) begin
                k  = $urandom_range(0, model_q.size() - 1);
                ct = model_q[k].r1 ? model_q[k].t2 : model_q[k].t1;
            end
            step($urandom_range(0, 99) != 0, $urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1,
                 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
                 $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 1) == 1, ct, $urandom,
                 $urandom_range(0, 3) != 0);
        end
        idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/int_issue_queue.md
Name: int_issue_queue

Overview:
- Integer reservation station that feeds the 32-bit ALU.
- Buffers dispatched ALU ops, captures operands from the common data bus (CDB) and issues the oldest fully-ready op.
- Issue output carries the two operands, the 4-bit ALU op code and the destination ROB tag.
- Sits between rename/dispatch and the ALU; the ALU result returns to the CDB with the issued tag.

Parameters:
- LENGTH, 32, operand width.
- DEPTH, 4, number of queue entries (>=2).
- TAG_W, 5, ROB/physical tag width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- flush_i  in  1  pipeline flush; discard all entries.
- disp_valid_i  in  1  dispatch request.
- disp_ready_o  out  1  queue can accept (not full).
- disp_op_i  in  4  ALU op code, 4'h0..4'hA.
- disp_dst_tag_i  in  TAG_W  destination tag.
- disp_srcN_rdy_i  in  1  operand N already available (N=1,2).
- disp_srcN_tag_i  in  TAG_W  producer tag when not ready.
- disp_srcN_val_i  in  LENGTH  operand value when ready.
- cdb_valid_i  in  1  CDB broadcast valid.
- cdb_tag_i  in  TAG_W  broadcast tag.
- cdb_data_i  in  LENGTH  broadcast value.
- issue_valid_o  out  1  an op is presented to the ALU.
- issue_ready_i  in  1  ALU accepts.
- issue_op_o  out  4  ALU op code.
- issue_a_o, issue_b_o  out  LENGTH  operands.
- issue_dst_tag_o  out  TAG_W  destination tag.
- count_o  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset (rst_n=0 at posedge): all entry valid bits 0, count_o=0, disp_ready_o=1, issue_valid_o=0. Issue data outputs are 0 when issue_valid_o=0.
- Ordering: the queue is age-ordered and compacting. Entry 0 is oldest; entries 0..count-1 are valid.
- Dispatch: accepted when disp_valid_i & disp_ready_o. The new op is written at index count, or count-1 if an issue fires the same cycle.
- disp_ready_o = (count < DEPTH). It does not depend on a same-cycle issue, so there is no combinational path from issue_ready_i.
- Wakeup: each cycle cdb_valid_i=1, every valid entry whose operand is not ready and tag == cdb_tag_i stores cdb_data_i and sets ready.
  - This also applies to an op dispatched the same cycle whose srcN tag matches.
  - One CDB per cycle; a tag matching both operands sets both.
- Select: combinational. The lowest-index entry with both operands ready drives the issue_* outputs and issue_valid_o=1.
- Issue: on issue_valid_o & issue_ready_i the selected entry is removed; entries above shift down one index.
  - If issue_ready_i=0, outputs stay stable on the same entry unless an older entry becomes ready, in which case the older entry wins.
- Latency: dispatch with both operands ready gives issue_valid_o in the next cycle. A CDB wakeup gives issue in the next cycle.
- Full: count=DEPTH gives disp_ready_o=0. Dispatch in that cycle is ignored even if an issue fires.
- Empty: issue_valid_o=0.
- Flush: flush_i=1 clears all valid bits next cycle and has priority over dispatch, issue bookkeeping and wakeup. issue_valid_o still reflects the pre-flush state in the flush cycle.
- Reset mid-operation: everything is discarded and there is no partial issue.
- Op codes pass through unchanged. Codes above 4'hA are accepted and issued; the ALU produces 0 for them.

Optional Feature:
- Macro: IQ_CDB_BYPASS_EN.
- Defined: an entry whose only missing operand(s) match the current CDB broadcast is eligible for select in the same cycle, with cdb_data_i muxed onto issue_a_o/issue_b_o. Wakeup-to-issue latency is 0 cycles.
- Undefined: selection considers only registered ready bits, so wakeup-to-issue latency is 1 cycle.

Decomposition:
- Package riscv_core_pkg holds:
  - typedef enum logic [3:0] alu_op_e (ADD=0, SUB, MUL, SLL, SLT, XOR, SRL, OR, AND, SLLI, SRLI=4'hA);
  - typedef struct iq_entry_t (valid, op, dst_tag, rdy1/2, tag1/2, val1/2);
  - localparam IQ_CNT_W.
- One sub-module, iq_oldest_picker: a priority encoder over the DEPTH ready vector that returns a one-hot grant and index.

Test Plan:
- Reset → count_o=0, issue_valid_o=0, disp_ready_o=1. Dispatch ADD(0) with val 5,7 ready, dst 3 → next cycle issue_op_o=0, a=5, b=7, dst=3; issue_ready_i=1 → count_o=0.
- Dispatch SUB dst 1 waiting on tag 9, then XOR dst 2 with both ready → XOR issues first. CDB tag 9 data 0x20 → next cycle SUB issues with a=0x20.
- Fill 4 entries, none ready → disp_ready_o=0 and a 5th dispatch is ignored. A CDB tag matching entry 2 → that entry issues, count 4→3, entries 3→2 shift and order is preserved.
- Dispatch an op with src2 tag 6 in the same cycle as CDB tag 6 data 0xFFFF_FFFF → operand captured, issues next cycle with b=0xFFFF_FFFF.
- 3 entries valid, flush_i=1 with simultaneous dispatch → next cycle count_o=0, issue_valid_o=0. rst_n=0 mid-stream → same result.
- With IQ_CDB_BYPASS_EN defined: entry waiting on tag 4, CDB tag 4 data 0x11 → issue_valid_o=1 and issue_a_o=0x11 in the same cycle. Without the macro → issue happens one cycle later.
